rand_pick_requester: RTL and testbench

- Requester-side front end for the 4-way random-start one-hot picker used by the minbd port allocators.
- Buffers flits from four input lanes in per-lane FIFOs and drives the 4-bit request vector and the 2-bit random start index into the picker.
- Consumes the picker's one-hot grant, pops the granted lane and presents the flit on a registered valid/ready output stage.
- Owns the LFSR that generates the random start index.

---
 rtl/rand_pick_requester.sv | 118 +++++++++++
 tb/tb_rand_pick_requester.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rand_pick_requester.sv
// Requester front end for the 4-way random-start picker: per-lane FIFOs,
// LFSR start index, grant checking and a registered valid/ready output stage.
module rand_pick_requester #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            in_valid,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic [3:0]            in_ready,
    output logic [3:0]            req_vec,
    output logic [1:0]            rand_num,
    input  logic [3:0]            grant,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_port,
    input  logic                  out_ready,
    output logic                  grant_err
);

    localparam int unsigned LANES = 4;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    // An all-zero seed would lock the LFSR, so it is replaced.
    localparam logic [7:0]  SEED  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    logic [DATA_W-1:0] mem    [LANES][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [LANES];
    logic [PTR_W-1:0]  rd_ptr [LANES];
    logic [CNT_W-1:0]  count  [LANES];
    logic [7:0]        lfsr;
    logic [3:0]        push;
    logic [3:0]        pop;
    logic              load_en;
    logic              grant_onehot;
    logic              grant_ok;
    logic              take;
    logic [1:0]        grant_idx;
    logic [DATA_W-1:0] head_data;

    // Lane status is derived from registered counts only.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            in_ready[i] = (count[i] != CNT_W'(DEPTH));
            req_vec[i]  = (count[i] != '0);
            push[i]     = in_valid[i] && in_ready[i];
        end
    end

    assign grant_onehot = (grant != 4'b0) && ((grant & (grant - 4'd1)) == 4'b0);
    assign grant_ok     = grant_onehot && ((grant & ~req_vec) == 4'b0);
    assign load_en      = !out_valid || out_ready;
    assign take         = load_en && grant_ok;
    assign pop          = take ? grant : 4'b0;
    assign rand_num     = lfsr[1:0];

    always_comb begin
        grant_idx = 2'd0;
        for (int i = 0; i < LANES; i++) begin
            if (grant[i]) begin
                grant_idx = 2'(i);
            end
        end
        head_data = mem[grant_idx][rd_ptr[grant_idx]];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
        end
    end

    // Output register, error pulse and LFSR (taps 8,6,5,4).
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_port  <= 2'd0;
            grant_err <= 1'b0;
            lfsr      <= SEED;
        end else begin
            lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            grant_err <= (grant != 4'b0) && !grant_ok;
            if (load_en) begin
                out_valid <= grant_ok;
                if (grant_ok) begin
                    out_data <= head_data;
                    out_port <= grant_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_rand_pick_requester.sv
// Self-checking bench for rand_pick_requester: queue-based model compared every
// cycle, plus directed literal checks and a fairness run with a picker model.
module tb_rand_pick_requester;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  SEED  = 8'hA5;

    logic          clk;
    logic          reset;
    logic [3:0]    in_valid;
    logic [4*DW-1:0] in_data;
    logic [3:0]    in_ready;
    logic [3:0]    req_vec;
    logic [1:0]    rand_num;
    logic [3:0]    grant;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_port;
    logic          out_ready;
    logic          grant_err;

    rand_pick_requester #(.DATA_W(DW), .DEPTH(DEPTH), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .req_vec(req_vec), .rand_num(rand_num), .grant(grant),
        .out_valid(out_valid), .out_data(out_data), .out_port(out_port),
        .out_ready(out_ready), .grant_err(grant_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Picker stand-in: start at rand_num, first requesting lane going upward.
    logic       gmode;
    logic [3:0] gforce;

    function automatic logic [3:0] pick(input logic [3:0] req, input logic [1:0] start);
        logic [1:0] idx;
        pick = 4'b0;
        for (int k = 0; k < 4; k++) begin
            idx = 2'(start + 2'(k));
            if (req[idx] && pick == 4'b0) pick = 4'b1 << idx;
        end
    endfunction

    always_comb begin
        if (gmode) grant = gforce;
        else       grant = pick(req_vec, rand_num);
    end

    // Reference model: one queue per lane plus the output register contents.
    logic [DW-1:0] mq [4][$];
    logic [7:0]    m_lfsr;
    logic          m_ov;
    logic [DW-1:0] m_od;
    logic [1:0]    m_op;
    logic          m_err;
    logic          m_known = 1'b0;

    always @(negedge clk) begin
        logic [3:0] m_req;
        logic [3:0] m_rdy;
        logic [3:0] acc;
        logic       legal;
        int         g;
        for (int i = 0; i < 4; i++) begin
            m_req[i] = (mq[i].size() != 0);
            m_rdy[i] = (mq[i].size() < DEPTH);
        end
        if (m_known) begin
            chk("req_vec", 32'(req_vec), 32'(m_req));
            chk("in_ready", 32'(in_ready), 32'(m_rdy));
            chk("rand_num", 32'(rand_num), 32'(m_lfsr[1:0]));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("out_data", 32'(out_data), 32'(m_od));
            chk("out_port", 32'(out_port), 32'(m_op));
            chk("grant_err", 32'(grant_err), 32'(m_err));
        end
        if (reset) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_lfsr  = SEED;
            m_ov    = 1'b0;
            m_od    = '0;
            m_op    = 2'd0;
            m_err   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            acc   = in_valid & m_rdy;
            legal = ($countones(grant) == 1) && ((grant & m_req) == grant);
            m_err = (grant != 4'b0) && !legal;
            if (!m_ov || out_ready) begin
                if (legal) begin
                    g = 0;
                    for (int i = 0; i < 4; i++) if (grant[i]) g = i;
                    m_od = mq[g].pop_front();
                    m_op = 2'(g);
                    m_ov = 1'b1;
                end else begin
                    m_ov = 1'b0;
                end
            end
            for (int i = 0; i < 4; i++)
                if (acc[i]) mq[i].push_back(in_data[i*DW +: DW]);
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [13:0] seq [4];
    int          gcnt [4];
    logic [3:0]  acc_s;

    initial begin
        reset = 1'b1; in_valid = 4'hF; in_data = '0; out_ready = 1'b1;
        gmode = 1'b0; gforce = 4'b0;

        // Reset held two cycles with all lanes offering data.
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'hF);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_rand_num", 32'(rand_num), 32'h1);
        chk("rst_req_vec", 32'(req_vec), 32'h0);
        reset = 1'b0; in_valid = 4'h0;
        tick();
        chk("lfsr_step1", 32'(rand_num), 32'h2);   // A5 -> 4A
        tick();
        chk("lfsr_step2", 32'(rand_num), 32'h1);   // 4A -> 95

        // Single flit on lane 2.
        in_valid = 4'b0100; in_data[2*DW +: DW] = 16'h1234;
        tick();
        in_valid = 4'b0;
        chk("single_req", 32'(req_vec), 32'h4);
        tick();
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_data", 32'(out_data), 32'h1234);
        chk("single_port", 32'(out_port), 32'h2);
        chk("single_req_clr", 32'(req_vec), 32'h0);
        tick();

        // Backpressure: six offers on lane 0, first one moves to the output.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 4'b0001; in_data[0 +: DW] = 16'hA000 + 16'(k);
            tick();
        end
        in_valid = 4'b0;
        chk("full_in_ready0", 32'(in_ready[0]), 32'h0);
        tick(); tick();
        chk("hold_valid", 32'(out_valid), 32'h1);
        chk("hold_data", 32'(out_data), 32'hA000);
        chk("hold_full", 32'(in_ready[0]), 32'h0);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("drain_data", 32'(out_data), 32'(16'hA000 + 16'(k)));
            chk("drain_valid", 32'(out_valid), 32'h1);
        end
        tick();
        chk("drain_done", 32'(out_valid), 32'h0);

        // Illegal grants against req_vec 0011.
        gmode = 1'b1; gforce = 4'b0;
        in_valid = 4'b0011; in_data[0 +: DW] = 16'hB000; in_data[DW +: DW] = 16'hB001;
        tick();
        in_valid = 4'b0; gforce = 4'b0110;
        chk("ill_req", 32'(req_vec), 32'h3);
        tick();
        gforce = 4'b0100;
        chk("ill_err1", 32'(grant_err), 32'h1);
        tick();
        gforce = 4'b0;
        chk("ill_err2", 32'(grant_err), 32'h1);
        chk("ill_nopop", 32'(req_vec), 32'h3);
        tick();
        chk("zero_grant_err", 32'(grant_err), 32'h0);
        chk("zero_grant_req", 32'(req_vec), 32'h3);
        chk("ill_out_valid", 32'(out_valid), 32'h0);
        gmode = 1'b0;
        repeat (4) tick();

        // Fairness with every lane kept full.
        for (int i = 0; i < 4; i++) begin seq[i] = '0; gcnt[i] = 0; end
        in_valid = 4'hF;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++) in_data[i*DW +: DW] = {2'(i), seq[i]};
            acc_s = in_ready;
            tick();
            for (int i = 0; i < 4; i++) if (acc_s[i]) seq[i] = seq[i] + 14'd1;
            if (out_valid) gcnt[out_port] = gcnt[out_port] + 1;
        end
        for (int i = 0; i < 4; i++) begin
            chk("fair_lo", 32'(gcnt[i] >= 850), 32'h1);
            chk("fair_hi", 32'(gcnt[i] <= 1150), 32'h1);
        end

        // Reset in the middle of the stream.
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_req", 32'(req_vec), 32'h0);
        chk("mid_rst_rand", 32'(rand_num), 32'h1);
        chk("mid_rst_ready", 32'(in_ready), 32'hF);
        reset = 1'b0; in_valid = 4'b0;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
